// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: tracks in-flight destinations per post-Decode
// stage, stalls Decode on unforwardable hazards and registers Execute forward selects.
module hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int STAGES     = 3,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int BR_STAGE   = 2,
  parameter int CNT_W      = 32,
  parameter int FW_W       = $clog2(STAGES + 1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              IssueValid,
  input  logic [REG_AW-1:0] IssueRs,
  input  logic [REG_AW-1:0] IssueRt,
  input  logic              IssueUsesRs,
  input  logic              IssueUsesRt,
  input  logic [REG_AW-1:0] IssueDest,
  input  logic              IssueWrites,
  input  logic              IssueIsLoad,
  input  logic              BranchTaken,
  output logic              StallD,
  output logic              FlushD,
  output logic [FW_W-1:0]   ForwardAE,
  output logic [FW_W-1:0]   ForwardBE,
  output logic              ValidE,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  if (!(ALU_READY >= 0 && ALU_READY <= LOAD_READY && LOAD_READY <= STAGES - 1)) begin : g_bad_ready
    $error("hazard_scoreboard: need ALU_READY <= LOAD_READY <= STAGES-1");
  end
  if (!(BR_STAGE >= 1 && BR_STAGE <= STAGES - 1)) begin : g_bad_br
    $error("hazard_scoreboard: need 1 <= BR_STAGE <= STAGES-1");
  end

  logic              vld_q  [STAGES];
  logic [REG_AW-1:0] dest_q [STAGES];
  logic              wr_q   [STAGES];
  logic              ld_q   [STAGES];

  logic              hit_a, ok_a, hit_b, ok_b;
  logic [FW_W-1:0]   sel_a, sel_b;
  logic              issue_d;
  logic [FW_W-1:0]   fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  // Scans oldest to youngest so the youngest producer is the one left standing.
  // A producer retiring this edge is visible through the write-first register file.
  function automatic void lookup(input  logic [REG_AW-1:0] src,
                                 input  logic              uses,
                                 output logic              hit,
                                 output logic              ok,
                                 output logic [FW_W-1:0]   sel);
    hit = 1'b0;
    ok  = 1'b1;
    sel = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      if (uses && src != '0 && vld_q[s] && wr_q[s] && dest_q[s] == src) begin
        hit = 1'b1;
        ok  = (s + 1 >= (ld_q[s] ? LOAD_READY : ALU_READY));
        sel = (s + 1 <= STAGES - 1) ? FW_W'(s + 1) : '0;
      end
    end
  endfunction

  always_comb begin
    lookup(IssueRs, IssueUsesRs, hit_a, ok_a, sel_a);
    lookup(IssueRt, IssueUsesRt, hit_b, ok_b, sel_b);
  end

  assign FlushD  = BranchTaken & ~Rst;
  assign StallD  = ~Rst & IssueValid & ~BranchTaken & ((hit_a & ~ok_a) | (hit_b & ~ok_b));
  assign issue_d = IssueValid & ~StallD & ~BranchTaken;

  always_comb begin
    fwd_a_d     = issue_d ? sel_a : '0;
    fwd_b_d     = issue_d ? sel_b : '0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (BranchTaken && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Control state: valid bits, forward selects and counters.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int s = 0; s < STAGES; s++) vld_q[s] <= 1'b0;
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      vld_q[0] <= issue_d;
      for (int s = 1; s < STAGES; s++)
        vld_q[s] <= vld_q[s-1] & ~(BranchTaken & (s < BR_STAGE - 1));
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Entry payload only matters while its valid bit is set.
  always_ff @(posedge Clk) begin
    dest_q[0] <= IssueDest;
    wr_q[0]   <= IssueWrites;
    ld_q[0]   <= IssueIsLoad;
    for (int s = 1; s < STAGES; s++) begin
      dest_q[s] <= dest_q[s-1];
      wr_q[s]   <= wr_q[s-1];
      ld_q[s]   <= ld_q[s-1];
    end
  end

  assign ValidE     = vld_q[0];
  assign ForwardAE  = fwd_a_q;
  assign ForwardBE  = fwd_b_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed MIPS sequences with literal expectations,
// then randomized traffic checked every negedge against an in-bench pipeline model.
module tb_hazard_scoreboard;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       IssueValid = 1'b0;
  logic [4:0] IssueRs = '0, IssueRt = '0, IssueDest = '0;
  logic       IssueUsesRs = 1'b0, IssueUsesRt = 1'b0;
  logic       IssueWrites = 1'b0, IssueIsLoad = 1'b0, BranchTaken = 1'b0;

  logic        StallD, FlushD, ValidE, StallD4, FlushD4, ValidE4;
  logic [1:0]  ForwardAE, ForwardBE, ForwardAE4, ForwardBE4;
  logic [31:0] StallCount, FlushCount;
  logic [3:0]  StallCount4, FlushCount4;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  hazard_scoreboard dut (
    .Clk(Clk), .Rst(Rst), .IssueValid(IssueValid), .IssueRs(IssueRs), .IssueRt(IssueRt),
    .IssueUsesRs(IssueUsesRs), .IssueUsesRt(IssueUsesRt), .IssueDest(IssueDest),
    .IssueWrites(IssueWrites), .IssueIsLoad(IssueIsLoad), .BranchTaken(BranchTaken),
    .StallD(StallD), .FlushD(FlushD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ValidE(ValidE), .StallCount(StallCount), .FlushCount(FlushCount));

  hazard_scoreboard #(.CNT_W(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .IssueValid(IssueValid), .IssueRs(IssueRs), .IssueRt(IssueRt),
    .IssueUsesRs(IssueUsesRs), .IssueUsesRt(IssueUsesRt), .IssueDest(IssueDest),
    .IssueWrites(IssueWrites), .IssueIsLoad(IssueIsLoad), .BranchTaken(BranchTaken),
    .StallD(StallD4), .FlushD(FlushD4), .ForwardAE(ForwardAE4), .ForwardBE(ForwardBE4),
    .ValidE(ValidE4), .StallCount(StallCount4), .FlushCount(FlushCount4));

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the instructions in flight, indexed by how many edges ago they issued.
  typedef struct packed {bit v; bit [4:0] d; bit w; bit ld;} ent_t;
  ent_t   pipe [3];
  int     m_fa = 0, m_fb = 0;
  bit     m_ve = 0;
  longint m_sc = 0, m_fc = 0, m_sc4 = 0, m_fc4 = 0;
  bit     ha, oa, hb, ob, st, iss;
  int     sa, sb;

  function automatic void look(input bit [4:0] src, input bit uses,
                               output bit hit, output bit ok, output int sel);
    hit = 0; ok = 1; sel = 0;
    if (!uses || src == 0) return;
    for (int age = 0; age < 3; age++) begin
      if (pipe[age].v && pipe[age].w && pipe[age].d == src) begin
        hit = 1;
        ok  = (age + 1) >= (pipe[age].ld ? 2 : 1);
        sel = (age + 1 <= 2) ? age + 1 : 0;
        return;
      end
    end
  endfunction

  function automatic bit m_stall();
    bit h1, o1, h2, o2;
    int s1, s2;
    look(IssueRs, IssueUsesRs, h1, o1, s1);
    look(IssueRt, IssueUsesRt, h2, o2, s2);
    return !Rst && IssueValid && !BranchTaken && ((h1 && !o1) || (h2 && !o2));
  endfunction

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      m_fa = 0; m_fb = 0; m_ve = 0;
      m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
    end else begin
      look(IssueRs, IssueUsesRs, ha, oa, sa);
      look(IssueRt, IssueUsesRt, hb, ob, sb);
      st  = m_stall();
      iss = IssueValid && !st && !BranchTaken;
      if (st) begin m_sc++; if (m_sc4 < 15) m_sc4++; end
      if (BranchTaken) begin m_fc++; if (m_fc4 < 15) m_fc4++; end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = '{v: iss, d: IssueDest, w: IssueWrites, ld: IssueIsLoad};
      m_fa = iss ? sa : 0;
      m_fb = iss ? sb : 0;
      m_ve = iss;
    end
  end

  always @(negedge Clk) begin
    chk("stallD", StallD, m_stall());
    chk("flushD", FlushD, !Rst && BranchTaken);
    chk("validE", ValidE, m_ve);
    chk("fwdAE", ForwardAE, m_fa);
    chk("fwdBE", ForwardBE, m_fb);
    chk("stallCnt", StallCount, m_sc);
    chk("flushCnt", FlushCount, m_fc);
    chk("stallCnt4", StallCount4, m_sc4);
    chk("flushCnt4", FlushCount4, m_fc4);
  end

  task automatic drv(bit v, int rs, int rt, bit urs, bit urt, int dst, bit wr, bit ld, bit bt);
    IssueValid  = v;
    IssueRs     = 5'(rs);
    IssueRt     = 5'(rt);
    IssueUsesRs = urs;
    IssueUsesRt = urt;
    IssueDest   = 5'(dst);
    IssueWrites = wr;
    IssueIsLoad = ld;
    BranchTaken = bt;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic nops(int n);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    drv(1, 1, 1, 1, 1, 1, 1, 0, 1);
    #2;
    chk("rst_flushD", FlushD, 0);
    chk("rst_stallD", StallD, 0);
    chk("rst_validE", ValidE, 0);
    tick(); tick();
    Rst = 1'b0;
    nops(1);

    // add $3,$1,$2 ; sub $4,$3,$5
    drv(1, 1, 2, 1, 1, 3, 1, 0, 0); #1 chk("alu_p_stall", StallD, 0); tick();
    drv(1, 3, 5, 1, 1, 4, 1, 0, 0); #1 chk("alu_c_stall", StallD, 0); tick();
    chk("alu_fa", ForwardAE, 1); chk("alu_fb", ForwardBE, 0); chk("alu_ve", ValidE, 1);
    nops(3);

    // lw $2,0($0) ; add $4,$2,$2
    drv(1, 0, 0, 1, 0, 2, 1, 1, 0); tick();
    drv(1, 2, 2, 1, 1, 4, 1, 0, 0); #1 chk("lu_stall", StallD, 1); tick();
    chk("lu_bubble", ValidE, 0); chk("lu_cnt", StallCount, 1);
    #1 chk("lu_stall_rel", StallD, 0); tick();
    chk("lu_fa", ForwardAE, 2); chk("lu_fb", ForwardBE, 2); chk("lu_ve", ValidE, 1);
    nops(3);

    // add $0,$1,$1 ; add $5,$0,$0
    drv(1, 1, 1, 1, 1, 0, 1, 0, 0); tick();
    drv(1, 0, 0, 1, 1, 5, 1, 0, 0); #1 chk("r0_stall", StallD, 0); tick();
    chk("r0_fa", ForwardAE, 0); chk("r0_fb", ForwardBE, 0);
    nops(3);

    // add $3 ; add $3 ; or $6,$3,$0
    drv(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
    drv(1, 4, 5, 1, 1, 3, 1, 0, 0); tick();
    drv(1, 3, 0, 1, 1, 6, 1, 0, 0); tick();
    chk("young_fa", ForwardAE, 1); chk("young_fb", ForwardBE, 0);
    nops(3);

    // branch while Decode holds a load-use consumer
    drv(1, 0, 0, 1, 0, 2, 1, 1, 0); tick();
    drv(1, 2, 2, 1, 1, 4, 1, 0, 1);
    #1 chk("br_stall", StallD, 0); chk("br_flush", FlushD, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_bubble", ValidE, 0); chk("br_fcnt", FlushCount, 1); chk("br_scnt", StallCount, 1);
    nops(3);

    // asynchronous reset in the middle of a load-use stall
    drv(1, 0, 0, 1, 0, 2, 1, 1, 0); tick();
    drv(1, 2, 2, 1, 1, 4, 1, 0, 0); #1 chk("ar_pre_stall", StallD, 1);
    chk("ar_pre_ve", ValidE, 1);
    Rst = 1'b1;
    #1 chk("ar_ve", ValidE, 0); chk("ar_stall", StallD, 0);
    chk("ar_scnt", StallCount, 0); chk("ar_fcnt", FlushCount, 0);
    tick();
    Rst = 1'b0;
    #1 chk("ar_reeval", StallD, 0); tick();
    chk("ar_issue_ve", ValidE, 1); chk("ar_issue_fa", ForwardAE, 0);
    nops(3);

    // 20 load-use stalls: narrow counter pins at all-ones
    for (int i = 0; i < 20; i++) begin
      drv(1, 0, 0, 1, 0, 2, 1, 1, 0); tick();
      drv(1, 2, 3, 1, 1, 4, 1, 0, 0); tick(); tick();
    end
    nops(3);
    chk("sat_cnt4", StallCount4, 15);
    chk("sat_cnt32", StallCount, 20);

    for (int i = 0; i < 1500; i++) begin
      drv($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
          $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8);
      if ($urandom_range(0, 299) == 0) begin
        #2 Rst = 1'b1;
        tick();
        Rst = 1'b0;
      end else begin
        tick();
      end
    end
    nops(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the pipelined MIPS core.
- Replaces ad-hoc load-use detection in the Fetch stage with a scoreboard of in-flight destination registers for every post-Decode stage.
- Drives registered forwarding selects for the Execute stage, a Decode stall/bubble, and branch flush.
- Keeps saturating stall and flush event counters.

Parameters:
- REG_AW, 5: register address width.
- STAGES, 3: number of tracked stages after Decode. Index 0=E, 1=M, 2=W.
- ALU_READY, 1: lowest stage index from which an ALU result can be forwarded.
- LOAD_READY, 2: lowest stage index from which load data can be forwarded.
- BR_STAGE, 2: stage index at which BranchTaken is resolved. Stages below it are younger.
- CNT_W, 32: width of the event counters.
- FW_W, clog2(STAGES+1): width of a forward select.

Ports:
- Clk, in, 1: clock.
- Rst, in, 1: asynchronous reset, active-high.
- IssueValid, in, 1: Decode holds a real instruction.
- IssueRs, in, REG_AW: rs source register.
- IssueRt, in, REG_AW: rt source register.
- IssueUsesRs, in, 1: instruction reads rs.
- IssueUsesRt, in, 1: instruction reads rt.
- IssueDest, in, REG_AW: destination register (after RegDst selection).
- IssueWrites, in, 1: instruction writes the register file.
- IssueIsLoad, in, 1: instruction is lw.
- BranchTaken, in, 1: branch resolved taken this cycle.
- StallD, out, 1: hold PC and the F/D register; insert a bubble into E. Combinational.
- FlushD, out, 1: invalidate the F/D register. Combinational, equal to BranchTaken.
- ForwardAE, out, FW_W: source select for SrcA of the instruction in E. Registered.
- ForwardBE, out, FW_W: source select for SrcB/WriteData of the instruction in E. Registered.
- ValidE, out, 1: the E-stage entry is a real instruction. Registered.
- StallCount, out, CNT_W: cycles with StallD=1.
- FlushCount, out, CNT_W: cycles with BranchTaken=1.

Behaviour:
- Scoreboard: entry[s] for s=0..STAGES-1, each holding {valid, dest, writes, isload}. Every edge shifts entry[s]→entry[s+1]; entry[STAGES-1] retires.
- Producer match for source x: entry[s].valid & writes & dest==x & x!=0 & the corresponding Uses bit. Register 0 never matches.
- Youngest match (smallest s) wins. Older matches are ignored.
- Ready index of a producer: LOAD_READY if isload, else ALU_READY.
- Producer at s is forwardable iff s+1 >= ready. When the consumer enters E, the producer sits at s+1.
- Forward select = s+1 if s+1 <= STAGES-1; 0 (register file) if no match or if the producer retires that edge.
- The register file is write-first, so a value retiring at W is visible to a same-cycle Decode read.
- StallD=1 iff IssueValid & any youngest match is not forwardable & !BranchTaken.
- Edge, normal: entry[0] <= issue fields with valid=IssueValid. ForwardAE/BE <= computed selects.
- Edge, stall: entry[0] <= bubble (valid=0), ForwardAE/BE <= 0. Older entries still advance.
- Edge, flush (BranchTaken=1): entries with index < BR_STAGE-1 after the shift are invalidated; the Decode instruction is not issued (entry[0] <= bubble). Flush has priority over stall, so StallD=0 in that cycle.
- Default configuration: a load immediately followed by a dependent instruction gives exactly 1 stall cycle and then ForwardXE=2. An ALU dependency gives 0 stalls and ForwardXE=1. A dependency at distance 3 gives select 0.
- Counters: increment by 1 per qualifying cycle and saturate at all-ones. They are never cleared except by Rst.
- Reset: all valid bits=0, ForwardAE=ForwardBE=0, ValidE=0, StallCount=FlushCount=0. StallD=0 and FlushD=0 while Rst is high.
- Reset mid-stall fully clears the scoreboard; the instruction held in Decode is re-evaluated after release.
- IssueValid=0 issues a bubble and never stalls.
- Parameter legality: ALU_READY <= LOAD_READY <= STAGES-1 and 1 <= BR_STAGE <= STAGES-1. Elaboration errors otherwise.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 → StallD=0 for both. The cycle after sub issues: ForwardAE=1, ForwardBE=0, ValidE=1.
- lw $2,0($0) then add $4,$2,$2 → StallD=1 for one cycle, then ValidE=0 for one cycle. Next: ForwardAE=ForwardBE=2. StallCount=1.
- add $0,$1,$1 then add $5,$0,$0 → no stall, ForwardAE=ForwardBE=0.
- add $3,.. ; add $3,.. ; or $6,$3,$0 → ForwardAE=1 (youngest producer wins, not 2).
- BranchTaken pulsed while Decode holds a load-use consumer → StallD=0, FlushD=1, entry[0] bubble, FlushCount=1, StallCount unchanged.
- CNT_W=4 with 20 consecutive stall cycles → StallCount holds at 15. Assert Rst mid-sequence → all outputs 0 immediately (asynchronous).
